mem_access_unit: RTL and testbench

- Parametrised memory access engine with a request/acknowledge interface.
- Combines a MAR, an MDR and a single-port synchronous RAM behind an FSM.
- Supports configurable wait states, multi-beat bursts with MAR auto-increment and wrap, and an abort.
- Sits between the datapath/control unit and storage; the datapath no longer toggles MAR/MDR enables by hand.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_access_unit_if.sv | 33 +++
 rtl/mem_access_unit_sp_ram.sv | 25 ++
 rtl/mem_access_unit.sv | 145 ++++++++++++++
 tb/tb_mem_access_unit.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory access unit.
//   state_e  : access engine FSM states
//   OP_READ  : op code latched for a read transaction
//   OP_WRITE : op code latched for a write transaction
//   wrap_inc : address increment that wraps modulo 2**width
package mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StAccess,
    StRdout,
    StDone
  } state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  function automatic int unsigned wrap_inc(input int unsigned a, input int unsigned width);
    int unsigned sum;
    sum = a + 32'd1;
    if (width >= 32) return sum;
    return sum & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge bus of the memory access unit.
//   master : datapath side, drives req/wr_rdn/addr/burst/abort/wdata
//   slave  : access unit side, drives wdata_ack/rdata/rdata_valid/busy/done/mar_q
interface mem_access_unit_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BURST_W    = 3
);

  logic                  req;
  logic                  wr_rdn;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BURST_W-1:0]    burst;
  logic                  abort;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wdata_ack;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_valid;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mar_q;

  modport master (
    output req, wr_rdn, addr, burst, abort, wdata,
    input  wdata_ack, rdata, rdata_valid, busy, done, mar_q
  );

  modport slave (
    input  req, wr_rdn, addr, burst, abort, wdata,
    output wdata_ack, rdata, rdata_valid, busy, done, mar_q
  );

endinterface

// File: rtl/mem_access_unit_sp_ram.sv
// Single-port synchronous RAM, no reset on the array.
//   clk  : clock, rising edge
//   we   : write enable, wd stored at addr on the edge
//   addr : shared read/write address
//   wd   : write data
//   rd   : registered read data (old contents on a same-edge write)
module sp_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] rd
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
    rd <= mem[addr];
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access engine: MAR, MDR and a single-port RAM sequenced by an FSM.
// Handles wait states, multi-beat bursts with wrapping MAR increment and abort.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : request/acknowledge bus (slave side), see mem_access_unit_if
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned BURST_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);

  localparam logic [3:0] WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mar_q, mar_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic [BURST_W-1:0]    beats_q, beats_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  op_q, op_d;

  logic                  start_beat;
  logic                  next_beat;
  logic                  wdata_ack;
  logic                  rdata_valid;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rd;

  always_comb begin
    state_d     = state_q;
    mar_d       = mar_q;
    mdr_d       = mdr_q;
    beats_d     = beats_q;
    wcnt_d      = wcnt_q;
    op_d        = op_q;
    start_beat  = 1'b0;
    next_beat   = 1'b0;
    wdata_ack   = 1'b0;
    rdata_valid = 1'b0;
    ram_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req && !bus.abort) begin
          mar_d      = bus.addr;
          beats_d    = bus.burst;
          op_d       = bus.wr_rdn;
          start_beat = 1'b1;
        end
      end
      StWait: begin
        if (bus.abort)          state_d = StIdle;
        else if (wcnt_q == '0)  state_d = StAccess;
        else                    wcnt_d  = wcnt_q - 4'd1;
      end
      StAccess: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (op_q == OP_WRITE) begin
          wdata_ack = 1'b1;
          ram_we    = 1'b1;
          next_beat = 1'b1;
        end else begin
          mdr_d   = ram_rd;
          state_d = StRdout;
        end
      end
      StRdout: begin
        rdata_valid = 1'b1;
        if (bus.abort) state_d = StIdle;
        else           next_beat = 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (next_beat) begin
      if (beats_q == '0) begin
        state_d = StDone;
      end else begin
        beats_d    = beats_q - 1'b1;
        mar_d      = ADDR_WIDTH'(wrap_inc(32'(mar_q), ADDR_WIDTH));
        start_beat = 1'b1;
      end
    end

    if (start_beat) begin
      if (WAIT_STATES > 0) begin
        state_d = StWait;
        wcnt_d  = WaitInit;
      end else begin
        state_d = StAccess;
      end
    end
  end

  // The RAM read is registered, so reads are addressed with the next MAR value:
  // the word for MAR is then on ram_rd throughout the read ACCESS cycle.
  // Writes address the current MAR.
  assign ram_addr = (state_q == StAccess && op_q == OP_WRITE) ? mar_q : mar_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      mar_q   <= '0;
      mdr_q   <= '0;
      beats_q <= '0;
      wcnt_q  <= '0;
      op_q    <= OP_READ;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      beats_q <= beats_d;
      wcnt_q  <= wcnt_d;
      op_q    <= op_d;
    end
  end

  sp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wd   (bus.wdata),
    .rd   (ram_rd)
  );

  assign bus.wdata_ack   = wdata_ack;
  assign bus.rdata_valid = rdata_valid;
  assign bus.rdata       = mdr_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.mar_q       = mar_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one instance with no wait states, one
// with two. Read data is checked through a scoreboard fed from a memory model.
module tb_mem_access_unit;

  logic       clk;
  logic       rst;
  logic       req;
  logic       wr_rdn;
  logic [7:0] addr;
  logic [2:0] burst;
  logic       abort;
  logic [7:0] wdata;
  int         sel;

  int         n_cmp;
  int         n_err;
  int         n_done;
  logic [7:0] sb[$];
  logic [7:0] model [2][256];

  mem_access_unit_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .BURST_W(3)) bus0 ();
  mem_access_unit_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .BURST_W(3)) bus2 ();

  assign bus0.req    = req & (sel == 0);
  assign bus2.req    = req & (sel == 1);
  assign bus0.wr_rdn = wr_rdn;
  assign bus2.wr_rdn = wr_rdn;
  assign bus0.addr   = addr;
  assign bus2.addr   = addr;
  assign bus0.burst  = burst;
  assign bus2.burst  = burst;
  assign bus0.abort  = abort;
  assign bus2.abort  = abort;
  assign bus0.wdata  = wdata;
  assign bus2.wdata  = wdata;

  mem_access_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(0), .BURST_W(3)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mem_access_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(2), .BURST_W(3)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  logic       obs_ack, obs_rv, obs_done, obs_busy;
  logic [7:0] obs_rdata, obs_mar;
  assign obs_ack   = (sel == 1) ? bus2.wdata_ack   : bus0.wdata_ack;
  assign obs_rv    = (sel == 1) ? bus2.rdata_valid : bus0.rdata_valid;
  assign obs_done  = (sel == 1) ? bus2.done        : bus0.done;
  assign obs_busy  = (sel == 1) ? bus2.busy        : bus0.busy;
  assign obs_rdata = (sel == 1) ? bus2.rdata       : bus0.rdata;
  assign obs_mar   = (sel == 1) ? bus2.mar_q       : bus0.mar_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every read beat pops one expected word.
  always @(negedge clk) begin
    if (obs_done) n_done++;
    if (obs_rv) begin
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) check("rdata", 32'(obs_rdata), 32'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flags sampled as {wdata_ack, rdata_valid, done, busy}.
  task automatic expect_cycle(input string tag, input logic [3:0] exp);
    @(negedge clk);
    check(tag, 32'({obs_ack, obs_rv, obs_done, obs_busy}), 32'(exp));
  endtask

  task automatic write_burst(input string tag, input logic [7:0] a, input int nb,
                             input logic [7:0] d0);
    int ws;
    ws = (sel == 1) ? 2 : 0;
    req = 1'b1; wr_rdn = 1'b1; addr = a; burst = 3'(nb - 1);
    tick();
    req = 1'b0;
    for (int b = 0; b < nb; b++) begin
      repeat (ws) begin
        expect_cycle({tag, "_wait"}, 4'b0001);
        tick();
      end
      wdata = 8'(d0 + 8'(b));
      expect_cycle({tag, "_acc"}, 4'b1001);
      check({tag, "_mar"}, 32'(obs_mar), 32'(8'(a + 8'(b))));
      model[sel][8'(a + 8'(b))] = wdata;
      tick();
    end
    expect_cycle({tag, "_done"}, 4'b0011);
    tick();
    expect_cycle({tag, "_idle"}, 4'b0000);
  endtask

  task automatic read_burst(input string tag, input logic [7:0] a, input int nb);
    int ws;
    ws = (sel == 1) ? 2 : 0;
    req = 1'b1; wr_rdn = 1'b0; addr = a; burst = 3'(nb - 1);
    tick();
    req = 1'b0;
    for (int b = 0; b < nb; b++) begin
      repeat (ws) begin
        expect_cycle({tag, "_wait"}, 4'b0001);
        tick();
      end
      expect_cycle({tag, "_acc"}, 4'b0001);
      check({tag, "_mar"}, 32'(obs_mar), 32'(8'(a + 8'(b))));
      sb.push_back(model[sel][8'(a + 8'(b))]);
      tick();
      expect_cycle({tag, "_rdout"}, 4'b0101);
      tick();
    end
    expect_cycle({tag, "_done"}, 4'b0011);
    tick();
    expect_cycle({tag, "_idle"}, 4'b0000);
  endtask

  initial begin
    int d_before;
    n_cmp = 0; n_err = 0; n_done = 0;
    rst = 1'b0; req = 1'b0; wr_rdn = 1'b0; addr = '0; burst = '0;
    abort = 1'b0; wdata = '0; sel = 0;

    // Power-on reset values on both instances.
    #3;
    check("por0_flags", 32'({obs_ack, obs_rv, obs_done, obs_busy}), 32'd0);
    check("por0_mar", 32'(obs_mar), 32'd0);
    check("por0_rdata", 32'(obs_rdata), 32'd0);
    sel = 1;
    #1;
    check("por2_flags", 32'({obs_ack, obs_rv, obs_done, obs_busy}), 32'd0);
    check("por2_mar", 32'(obs_mar), 32'd0);
    #10;
    rst = 1'b1;
    tick();

    // No wait states: single write then single read.
    sel = 0;
    write_burst("ws0_wr", 8'h10, 1, 8'hA5);
    read_burst("ws0_rd", 8'h10, 1);

    // req held through DONE: second read starts only after the IDLE cycle.
    d_before = n_done;
    sb.push_back(model[0][8'h10]);
    sb.push_back(model[0][8'h10]);
    req = 1'b1; wr_rdn = 1'b0; addr = 8'h10; burst = 3'd0;
    tick();
    expect_cycle("b2b_acc1", 4'b0001);
    tick();
    expect_cycle("b2b_rdout1", 4'b0101);
    tick();
    expect_cycle("b2b_done1", 4'b0011);
    tick();
    expect_cycle("b2b_idle", 4'b0000);
    tick();
    req = 1'b0;
    expect_cycle("b2b_acc2", 4'b0001);
    tick();
    expect_cycle("b2b_rdout2", 4'b0101);
    tick();
    expect_cycle("b2b_done2", 4'b0011);
    tick();
    expect_cycle("b2b_idle2", 4'b0000);
    check("b2b_done_count", 32'(n_done - d_before), 32'd2);

    // abort together with req in IDLE drops the request.
    req = 1'b1; abort = 1'b1;
    tick();
    req = 1'b0; abort = 1'b0;
    expect_cycle("idle_abort", 4'b0000);

    // Two wait states: wrapping burst write and read-back.
    sel = 1;
    tick();
    write_burst("ws2_wr", 8'hFE, 4, 8'h01);
    read_burst("ws2_rd", 8'hFE, 4);

    // Abort in the second write ACCESS of a three-beat burst.
    write_burst("pre", 8'h20, 2, 8'h11);
    d_before = n_done;
    req = 1'b1; wr_rdn = 1'b1; addr = 8'h20; burst = 3'd2;
    tick();
    req = 1'b0;
    repeat (2) begin
      expect_cycle("abt_wait1", 4'b0001);
      tick();
    end
    wdata = 8'h77;
    expect_cycle("abt_acc1", 4'b1001);
    model[1][8'h20] = 8'h77;
    tick();
    repeat (2) begin
      expect_cycle("abt_wait2", 4'b0001);
      tick();
    end
    wdata = 8'h78; abort = 1'b1;
    expect_cycle("abt_acc2", 4'b0001);
    check("abt_mar", 32'(obs_mar), 32'h21);
    tick();
    abort = 1'b0;
    expect_cycle("abt_idle", 4'b0000);
    check("abt_mar_hold", 32'(obs_mar), 32'h21);
    check("abt_no_done", 32'(n_done - d_before), 32'd0);
    read_burst("abt_rd", 8'h20, 2);

    // Reset asserted during WAIT of a write.
    tick();
    req = 1'b1; wr_rdn = 1'b1; addr = 8'h40; burst = 3'd1; wdata = 8'h99;
    tick();
    req = 1'b0;
    expect_cycle("rst_wait", 4'b0001);
    #2;
    rst = 1'b0;
    #1;
    check("rst_flags", 32'({obs_ack, obs_rv, obs_done, obs_busy}), 32'd0);
    check("rst_mar", 32'(obs_mar), 32'd0);
    check("rst_rdata", 32'(obs_rdata), 32'd0);
    tick();
    #2;
    rst = 1'b1;
    tick();
    write_burst("post_rst_wr", 8'h40, 1, 8'h3C);
    read_burst("post_rst_rd", 8'h40, 1);

    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
